// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state, entry type and constants for the writeback arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, PENDING, FORCE} state_e;
  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_pending_fifo.sv
// wb_pending_fifo: circular buffer of late results with kill-by-register and lookup
module wb_pending_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     push_live_i,
  input  logic [4:0]               push_reg_i,
  input  logic [31:0]              push_data_i,
  input  logic                     pop_i,
  input  logic                     kill_i,
  input  logic [4:0]               kill_reg_i,
  input  logic [4:0]               query_reg_i,
  output logic                     match_o,
  output logic                     head_live_o,
  output logic [4:0]               head_reg_o,
  output logic [31:0]              head_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rptr_q, wptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full_o      = cnt_q == (AW+1)'(DEPTH);
  assign empty_o     = cnt_q == '0;
  assign count_o     = cnt_q;
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign head_live_o = !empty_o && mem_q[rptr_q].live;
  assign head_reg_o  = mem_q[rptr_q].rd;
  assign head_data_o = mem_q[rptr_q].data;
  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      match_o = match_o | (mem_q[i].live && mem_q[i].rd == query_reg_i);
  end
  // Freed slots have live cleared so the lookup never sees stale entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_i && mem_q[i].rd == kill_reg_i) mem_q[i].live <= 1'b0;
      if (do_pop) begin
        mem_q[rptr_q].live <= 1'b0;
        rptr_q             <= rptr_q + AW'(1);
      end
      if (do_push) begin
        mem_q[wptr_q] <= '{live: push_live_i, rd: push_reg_i, data: push_data_i};
        wptr_q        <= wptr_q + AW'(1);
      end
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the register-file write port between the W stage and late results
module writeback_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_write_w_i,
  input  logic [4:0]  write_reg_w_i,
  input  logic [31:0] result_w_i,
  input  logic        late_valid_i,
  input  logic [4:0]  late_reg_i,
  input  logic [31:0] late_data_i,
  output logic        late_ready_o,
  output logic        stall_w_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_wa_o,
  output logic [31:0] rf_wd_o,
  input  logic [4:0]  query_reg_i,
  output logic        query_busy_o
);
  localparam int GW = $clog2(STARVE_LIMIT) + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  state_e        state_q, state_d;
  logic [GW-1:0] age_q, age_d;
  logic [CW-1:0] count;
  logic [4:0]    head_reg;
  logic [31:0]   head_data;
  logic          full, empty, head_live, match;
  logic          force_c, pipe_req, pipe_grant, late_grant, push, pop, push_live, nonempty_d;
  assign force_c      = state_q == FORCE;
  assign pipe_req     = reg_write_w_i && write_reg_w_i != REG_ZERO;
  assign pipe_grant   = !rst_i && !force_c && pipe_req;
  assign late_grant   = !rst_i && head_live && (force_c || !pipe_req);
  // Dead heads drain regardless of who owns the port.
  assign pop          = !rst_i && !empty && (force_c || !head_live || late_grant);
  assign late_ready_o = !rst_i && !full;
  assign push         = late_valid_i && late_ready_o && late_reg_i != REG_ZERO;
  assign push_live    = !(pipe_grant && late_reg_i == write_reg_w_i);
  assign stall_w_o    = !rst_i && force_c;
  assign rf_we_o      = pipe_grant || late_grant;
  assign rf_wa_o      = pipe_grant ? write_reg_w_i : late_grant ? head_reg : REG_ZERO;
  assign rf_wd_o      = pipe_grant ? result_w_i : late_grant ? head_data : '0;
  assign query_busy_o = !rst_i && match && query_reg_i != REG_ZERO;
  wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_live_i (push_live),
    .push_reg_i  (late_reg_i),
    .push_data_i (late_data_i),
    .pop_i       (pop),
    .kill_i      (pipe_grant),
    .kill_reg_i  (write_reg_w_i),
    .query_reg_i (query_reg_i),
    .match_o     (match),
    .head_live_o (head_live),
    .head_reg_o  (head_reg),
    .head_data_o (head_data),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );
  always_comb begin
    age_d      = (pop || empty) ? '0 : head_live ? age_q + GW'(1) : age_q;
    nonempty_d = push || count != CW'(pop);
    state_d    = (head_live && !pop && age_d == GW'(STARVE_LIMIT - 1)) ? FORCE :
                 nonempty_d ? PENDING : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end
endmodule
